// File: rtl/decode_queue_pkg.sv
// Shared types for decode_queue: queue entries, forwarding channels and the
// decoded bundle, plus the instruction decoder used on the queue head.
package pipes;

    typedef logic [63:0] word_t;
    typedef logic [4:0]  reg_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic branch;
        logic jump;
        logic alusrc;
    } ctl_t;

    typedef struct packed {
        word_t       pc;
        logic [31:0] instr;
    } decode_in_t;

    typedef struct packed {
        logic  valid;
        reg_t  dst;
        word_t data;
        logic  ismem;
    } fwd_t;

    typedef struct packed {
        word_t       pc;
        logic [31:0] instr;
        ctl_t        ctl;
        reg_t        dst;
        reg_t        srca;
        reg_t        srcb;
        word_t       rd1;
        word_t       rd2;
    } decode_data_t;

    typedef struct packed {
        ctl_t ctl;
        reg_t dst;
        reg_t srca;
        reg_t srcb;
    } dec_t;

    typedef struct packed {
        logic  stall;
        word_t data;
    } opnd_t;

    // Unused source fields come back as x0 so they never forward or stall.
    function automatic dec_t decode(
        input logic [6:0] op,
        input reg_t       rd,
        input reg_t       r1,
        input reg_t       r2
    );
        dec_t d;
        logic use1;
        logic use2;
        d    = '0;
        use1 = 1'b0;
        use2 = 1'b0;
        case (op)
            OP_LOAD: begin
                d.ctl.regwrite = 1'b1;
                d.ctl.memread  = 1'b1;
                d.ctl.alusrc   = 1'b1;
                use1           = 1'b1;
            end
            OP_STORE: begin
                d.ctl.memwrite = 1'b1;
                d.ctl.alusrc   = 1'b1;
                use1           = 1'b1;
                use2           = 1'b1;
            end
            OP_IMM, OP_IMM32: begin
                d.ctl.regwrite = 1'b1;
                d.ctl.alusrc   = 1'b1;
                use1           = 1'b1;
            end
            OP_REG, OP_REG32: begin
                d.ctl.regwrite = 1'b1;
                use1           = 1'b1;
                use2           = 1'b1;
            end
            OP_BRANCH: begin
                d.ctl.branch = 1'b1;
                use1         = 1'b1;
                use2         = 1'b1;
            end
            OP_JAL: begin
                d.ctl.regwrite = 1'b1;
                d.ctl.jump     = 1'b1;
            end
            OP_JALR: begin
                d.ctl.regwrite = 1'b1;
                d.ctl.jump     = 1'b1;
                d.ctl.alusrc   = 1'b1;
                use1           = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                d.ctl.regwrite = 1'b1;
                d.ctl.alusrc   = 1'b1;
            end
            default: ;
        endcase
        d.srca = use1 ? r1 : '0;
        d.srcb = use2 ? r2 : '0;
        d.dst  = d.ctl.regwrite ? rd : '0;
        return d;
    endfunction

endpackage

// File: rtl/decode_queue_fifo.sv
// decode_fifo: circular entry store for decode_queue with wrapping pointers
// and a fill count; flush and reset both return it to empty.
module decode_fifo
    import pipes::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int OW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  decode_in_t    wdata,
    output decode_in_t    rdata,
    output logic          head_valid,
    output logic [OW-1:0] occupancy
);

    decode_in_t    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    assign rdata      = mem[rptr];
    assign head_valid = occupancy != '0;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wptr      <= '0;
            rptr      <= '0;
            occupancy <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OW'(1);
                2'b01:   occupancy <= occupancy - OW'(1);
                default: ;
            endcase
        end
    end

    // Payload needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/decode_queue.sv
// Decode stage with an instruction queue, operand forwarding and hazard stall.
// Build option: DECODE_FWD_EN enables forwarding; otherwise matches stall.
module decode_queue
    import pipes::*;
#(
    parameter int DEPTH = 4,
    parameter int NFWD = 2,
    localparam int OW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  word_t                 in_pc,
    input  logic [31:0]           in_instr,
    output reg_t                  rs1,
    output reg_t                  rs2,
    input  word_t                 q1,
    input  word_t                 q2,
    input  logic [NFWD-1:0]       fwd_valid,
    input  logic [NFWD-1:0][4:0]  fwd_dst,
    input  logic [NFWD-1:0][63:0] fwd_data,
    input  logic [NFWD-1:0]       fwd_ismem,
    output logic                  out_valid,
    input  logic                  out_ready,
    output decode_data_t          dataD,
    output logic [OW-1:0]         occupancy
);

    decode_in_t          entry;
    decode_in_t          head;
    logic                head_valid;
    logic                push;
    logic                pop;
    logic                stall;
    dec_t                dec;
    opnd_t               op1;
    opnd_t               op2;
    fwd_t [NFWD-1:0]     fwd;

    assign in_ready = reset && (occupancy != OW'(DEPTH));
    assign push     = in_valid && in_ready && !flush;
    assign entry    = '{pc: in_pc, instr: in_instr};

    decode_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .pop        (pop),
        .wdata      (entry),
        .rdata      (head),
        .head_valid (head_valid),
        .occupancy  (occupancy)
    );

    always_comb begin
        for (int i = 0; i < NFWD; i++) begin
            fwd[i] = '{valid: fwd_valid[i], dst: fwd_dst[i],
                       data: fwd_data[i], ismem: fwd_ismem[i]};
        end
    end

    assign dec = decode(head.instr[6:0], head.instr[11:7],
                        head.instr[19:15], head.instr[24:20]);
    assign rs1 = dec.srca;
    assign rs2 = dec.srcb;

    // Scan oldest-to-youngest so the lowest matching channel wins.
    function automatic opnd_t sel(
        input reg_t            rs,
        input word_t           q,
        input fwd_t [NFWD-1:0] f
    );
        opnd_t o;
        logic  busy;
        logic  hold;
        busy   = out_valid && dataD.ctl.regwrite && (rs == dataD.dst);
        hold   = 1'b0;
        o.data = q;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (f[i].valid && f[i].dst == rs) begin
`ifdef DECODE_FWD_EN
                o.data = f[i].data;
                hold   = f[i].ismem;
`else
                hold   = 1'b1;
`endif
            end
        end
        o.stall = busy || hold;
        if (rs == '0) begin
            o.stall = 1'b0;
            o.data  = q;
        end
        return o;
    endfunction

    assign op1   = sel(dec.srca, q1, fwd);
    assign op2   = sel(dec.srcb, q2, fwd);
    assign stall = op1.stall || op2.stall;
    assign pop   = head_valid && !stall && (!out_valid || out_ready) && !flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            dataD     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            dataD     <= '{pc: head.pc, instr: head.instr, ctl: dec.ctl,
                           dst: dec.dst, srca: dec.srca, srcb: dec.srcb,
                           rd1: op1.data, rd2: op2.data};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: hazard vector table, scoreboard on the output
// handshake, and hand sequences for fill, RAW, load-use, flush and reset.
module tb_decode_queue;
    import pipes::*;

    localparam int DEPTH = 4;
    localparam int NFWD = 2;
    localparam int OW = $clog2(DEPTH + 1);

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  flush = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    word_t                 in_pc = '0;
    logic [31:0]           in_instr = '0;
    reg_t                  rs1;
    reg_t                  rs2;
    word_t                 q1;
    word_t                 q2;
    logic [NFWD-1:0]       fwd_valid = '0;
    logic [NFWD-1:0][4:0]  fwd_dst = '0;
    logic [NFWD-1:0][63:0] fwd_data = '0;
    logic [NFWD-1:0]       fwd_ismem = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    decode_data_t          dataD;
    logic [OW-1:0]         occupancy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        word_t pc;
        word_t rd1;
        word_t rd2;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic [1:0] fv;
        reg_t       d0;
        reg_t       d1;
        word_t      x0;
        word_t      x1;
        logic [1:0] fm;
        reg_t       a;
        reg_t       b;
        logic       st;
        word_t      e1;
        word_t      e2;
    } vec_t;
    vec_t vt[9];

    decode_queue #(.DEPTH(DEPTH), .NFWD(NFWD)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .rs1       (rs1),
        .rs2       (rs2),
        .q1        (q1),
        .q2        (q2),
        .fwd_valid (fwd_valid),
        .fwd_dst   (fwd_dst),
        .fwd_data  (fwd_data),
        .fwd_ismem (fwd_ismem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataD     (dataD),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    function automatic word_t qa(input reg_t r);
        return 64'h1000 + 64'(r);
    endfunction

    function automatic word_t qb(input reg_t r);
        return 64'h2000 + 64'(r);
    endfunction

    // Register file model: read data is a fixed function of the address.
    assign q1 = qa(rs1);
    assign q2 = qb(rs2);

    function automatic logic [31:0] i_add(input reg_t rd, input reg_t a, input reg_t b);
        return {7'b0, b, a, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_addi(input reg_t rd, input reg_t a, input logic [11:0] imm);
        return {imm, a, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic vec_t mk(
        input logic [1:0] fv, input reg_t d0, input reg_t d1,
        input word_t x0, input word_t x1, input logic [1:0] fm,
        input reg_t a, input reg_t b, input logic st,
        input word_t e1, input word_t e2
    );
        vec_t v;
        v.fv = fv; v.d0 = d0; v.d1 = d1; v.x0 = x0; v.x1 = x1; v.fm = fm;
        v.a = a; v.b = b; v.st = st; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Call at a falling edge; returns at the next falling edge.
    task automatic push(input word_t pc, input logic [31:0] ins, input word_t e1, input word_t e2);
        exp_t e;
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = ins;
        #1;
        if (in_ready) begin
            e.pc = pc; e.rd1 = e1; e.rd2 = e2;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        #2;
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual pc=%h required none", dataD.pc);
            end else begin
                mon_e = sb.pop_front();
                check("sb_pc", dataD.pc, mon_e.pc);
                check("sb_rd1", dataD.rd1, mon_e.rd1);
                check("sb_rd2", dataD.rd2, mon_e.rd2);
            end
        end
    end

    initial begin
        vt[0] = mk(2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 2'b00, 5'd5, 5'd6, 1'b0, qa(5'd5), qb(5'd6));
`ifdef DECODE_FWD_EN
        vt[1] = mk(2'b11, 5'd5, 5'd5, 64'hAA, 64'hBB, 2'b00, 5'd5, 5'd6, 1'b0, 64'hAA, qb(5'd6));
        vt[2] = mk(2'b11, 5'd9, 5'd6, 64'hAA, 64'hBB, 2'b00, 5'd5, 5'd6, 1'b0, qa(5'd5), 64'hBB);
        vt[5] = mk(2'b11, 5'd5, 5'd5, 64'hAA, 64'hBB, 2'b10, 5'd5, 5'd6, 1'b0, 64'hAA, qb(5'd6));
        vt[6] = mk(2'b10, 5'd5, 5'd5, 64'hAA, 64'hBB, 2'b01, 5'd5, 5'd6, 1'b0, 64'hBB, qb(5'd6));
        vt[7] = mk(2'b01, 5'd6, 5'd0, 64'hCC, 64'h0, 2'b00, 5'd6, 5'd6, 1'b0, 64'hCC, 64'hCC);
`else
        vt[1] = mk(2'b11, 5'd5, 5'd5, 64'hAA, 64'hBB, 2'b00, 5'd5, 5'd6, 1'b1, qa(5'd5), qb(5'd6));
        vt[2] = mk(2'b11, 5'd9, 5'd6, 64'hAA, 64'hBB, 2'b00, 5'd5, 5'd6, 1'b1, qa(5'd5), qb(5'd6));
        vt[5] = mk(2'b11, 5'd5, 5'd5, 64'hAA, 64'hBB, 2'b10, 5'd5, 5'd6, 1'b1, qa(5'd5), qb(5'd6));
        vt[6] = mk(2'b10, 5'd5, 5'd5, 64'hAA, 64'hBB, 2'b01, 5'd5, 5'd6, 1'b1, qa(5'd5), qb(5'd6));
        vt[7] = mk(2'b01, 5'd6, 5'd0, 64'hCC, 64'h0, 2'b00, 5'd6, 5'd6, 1'b1, qa(5'd6), qb(5'd6));
`endif
        vt[3] = mk(2'b11, 5'd0, 5'd0, 64'hAA, 64'hBB, 2'b11, 5'd0, 5'd0, 1'b0, qa(5'd0), qb(5'd0));
        vt[4] = mk(2'b01, 5'd7, 5'd0, 64'hCC, 64'h0, 2'b01, 5'd7, 5'd8, 1'b1, qa(5'd7), qb(5'd8));
        vt[8] = mk(2'b11, 5'd5, 5'd6, 64'hAA, 64'hBB, 2'b10, 5'd5, 5'd6, 1'b1, qa(5'd5), qb(5'd6));

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_occupancy", occupancy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_dataD_nonzero", 64'(dataD != '0), 0);
        reset = 1'b1;
        #1;
        check("rst_release_in_ready", in_ready, 1);
        @(negedge clk);

        // Fill and drain
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) begin
                #1;
                check("fill_occupancy", occupancy, 4);
                check("fill_in_ready", in_ready, 0);
                @(negedge clk);
            end
            push(64'h100 + 64'(i * 4), i_add(5'(20 + i), 5'(i), 5'(i + 8)),
                 qa(5'(i)), qb(5'(i + 8)));
        end
        #1;
        check("fill_refused_occ", occupancy, 4);
        check("fill_head_pc", dataD.pc, 64'h104);
        check("fill_sb_size", sb.size(), 5);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("drain_valid%0d", k), out_valid, 1);
            @(negedge clk);
            #1;
        end
        check("drain_done_valid", out_valid, 0);
        check("drain_done_occ", occupancy, 0);
        @(negedge clk);

        // Forwarding and hazard vectors
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            fwd_valid    = vt[i].fv;
            fwd_dst[0]   = vt[i].d0;
            fwd_dst[1]   = vt[i].d1;
            fwd_data[0]  = vt[i].x0;
            fwd_data[1]  = vt[i].x1;
            fwd_ismem    = vt[i].fm;
            push(64'h400 + 64'(i * 4), i_add(5'd10, vt[i].a, vt[i].b), vt[i].e1, vt[i].e2);
            @(negedge clk);
            #1;
            check($sformatf("vec%0d_issue", i), out_valid, 64'(!vt[i].st));
            fwd_valid = '0;
            repeat (2) @(negedge clk);
            #1;
            check($sformatf("vec%0d_empty", i), occupancy, 0);
            @(negedge clk);
        end

        // Load-use held until the load data is ready
        fwd_valid   = 2'b01;
        fwd_dst[0]  = 5'd7;
        fwd_data[0] = 64'hCC;
        fwd_ismem   = 2'b01;
`ifdef DECODE_FWD_EN
        push(64'h800, i_add(5'd11, 5'd7, 5'd8), 64'hDD, qb(5'd8));
`else
        push(64'h800, i_add(5'd11, 5'd7, 5'd8), qa(5'd7), qb(5'd8));
`endif
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("ldu_hold%0d", k), out_valid, 0);
        end
`ifdef DECODE_FWD_EN
        fwd_ismem   = 2'b00;
        fwd_data[0] = 64'hDD;
`else
        fwd_valid = 2'b00;
`endif
        @(negedge clk);
        #1;
        check("ldu_issue", out_valid, 1);
        fwd_valid = '0;
        fwd_ismem = '0;
        repeat (2) @(negedge clk);

        // Back-to-back RAW through the output slot
        out_ready = 1'b0;
        push(64'h900, i_addi(5'd3, 5'd0, 12'd5), qa(5'd0), qb(5'd0));
`ifdef DECODE_FWD_EN
        push(64'h904, i_add(5'd4, 5'd3, 5'd3), 64'h55, 64'h55);
`else
        push(64'h904, i_add(5'd4, 5'd3, 5'd3), qa(5'd3), qb(5'd3));
`endif
        #1;
        check("raw_first_pc", dataD.pc, 64'h900);
        check("raw_hold_occ", occupancy, 1);
        @(negedge clk);
        #1;
        check("raw_hold_pc", dataD.pc, 64'h900);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("raw_drain_valid", out_valid, 0);
        check("raw_drain_occ", occupancy, 1);
        fwd_valid   = 2'b01;
        fwd_dst[0]  = 5'd3;
        fwd_data[0] = 64'h55;
        fwd_ismem   = 2'b00;
        @(negedge clk);
        #1;
`ifndef DECODE_FWD_EN
        check("raw_fwd_stall", out_valid, 0);
        fwd_valid = '0;
        @(negedge clk);
        #1;
`endif
        check("raw_second_valid", out_valid, 1);
        check("raw_second_pc", dataD.pc, 64'h904);
        fwd_valid = '0;
        repeat (2) @(negedge clk);

        // Flush with a simultaneous push
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(64'hA00 + 64'(i * 4), i_add(5'd20, 5'(i + 1), 5'(i + 1)),
                 qa(5'(i + 1)), qb(5'(i + 1)));
        end
        #1;
        check("flush_pre_occ", occupancy, 3);
        check("flush_pre_valid", out_valid, 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 64'hB00;
        in_instr = i_add(5'd21, 5'd1, 5'd2);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        check("flush_occ", occupancy, 0);
        check("flush_valid", out_valid, 0);
        check("flush_payload_pc", dataD.pc, 64'hA00);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("flush_no_issue", out_valid, 0);
        check("flush_still_empty", occupancy, 0);
        @(negedge clk);

        // Reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(64'hC00 + 64'(i * 4), i_add(5'd22, 5'(i + 1), 5'(i + 2)),
                 qa(5'(i + 1)), qb(5'(i + 2)));
        end
        #1;
        check("mrst_pre_occ", occupancy, 2);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("mrst_occ", occupancy, 0);
        check("mrst_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 0);
        check("mrst_dataD_nonzero", 64'(dataD != '0), 0);
        sb.delete();
        reset = 1'b1;
        #1;
        check("mrst_release_in_ready", in_ready, 1);
        @(negedge clk);
        out_ready = 1'b1;
        push(64'hD00, i_add(5'd12, 5'd1, 5'd2), qa(5'd1), qb(5'd2));
        repeat (3) @(negedge clk);
        #1;
        check("final_sb_empty", sb.size(), 0);
        check("final_occ", occupancy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
